ship_datapath: RTL and testbench

- Datapath responder to the game control FSM: consumes its per-state enables (ship update, grid update, game over) and produces the player ship position, ship health, bullet spawn requests and the game-over LED pattern.
- Performs exactly one game-logic step per UPDATE-state entry, independent of how long the controller holds the enable.
- Feeds ship_health back to the controller, which enters GAMEOVER when health reaches 0.

---
 rtl/ship_datapath_if.sv | 28 ++
 rtl/ship_datapath.sv | 151 +++++++++++++++
 tb/tb_ship_datapath.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ship_datapath_if.sv
// rtl/ship_datapath_if.sv - controller/datapath signal bundle for the player ship datapath
interface ship_datapath_if;
    logic        ship_update_en;
    logic        grid_update_en;
    logic        game_over_en;
    logic        move_left;
    logic        move_right;
    logic        fire;
    logic        hit;
    logic [7:0]  user_x;
    logic [3:0]  ship_health;
    logic        shot_req;
    logic [7:0]  shot_x;
    logic [17:0] ledr;
    logic [7:0]  ledg;

    modport master (
        output ship_update_en, grid_update_en, game_over_en,
        output move_left, move_right, fire, hit,
        input  user_x, ship_health, shot_req, shot_x, ledr, ledg
    );

    modport slave (
        input  ship_update_en, grid_update_en, game_over_en,
        input  move_left, move_right, fire, hit,
        output user_x, ship_health, shot_req, shot_x, ledr, ledg
    );
endinterface

// File: rtl/ship_datapath.sv
// rtl/ship_datapath.sv - ship position, health, fire and game-over LED datapath
module ship_datapath #(
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 152,
    parameter int X_START       = 80,
    parameter int STEP          = 2,
    parameter int SHIP_HALF     = 4,
    parameter int HEALTH_INIT   = 8,
    parameter int FIRE_COOLDOWN = 4,
    parameter int INVULN_TICKS  = 8,
    parameter int LED_DIV       = 12500000
) (
    input  logic clk,
    input  logic reset,
    ship_datapath_if.slave bus
);
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 1);
    localparam int INV_W = $clog2(INVULN_TICKS + 1);
    localparam int DIV_W = $clog2(LED_DIV + 1);

    localparam logic [7:0]       X_MIN_V   = 8'(X_MIN);
    localparam logic [7:0]       X_MAX_V   = 8'(X_MAX);
    localparam logic [7:0]       X_START_V = 8'(X_START);
    localparam logic [7:0]       STEP_V    = 8'(STEP);
    localparam logic [7:0]       X_LO      = 8'(X_MIN + STEP);
    localparam logic [7:0]       X_HI      = 8'(X_MAX - STEP);
    localparam logic [7:0]       HALF_V    = 8'(SHIP_HALF);
    localparam logic [3:0]       HEALTH_V  = 4'(HEALTH_INIT);
    localparam logic [CD_W-1:0]  CD_V      = CD_W'(FIRE_COOLDOWN);
    localparam logic [INV_W-1:0] INV_V     = INV_W'(INVULN_TICKS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(LED_DIV - 1);

    logic             ship_en_q, go_en_q;
    logic [7:0]       x_q, x_d;
    logic [3:0]       health_q, health_d;
    logic [CD_W-1:0]  cooldown_q, cooldown_d;
    logic [INV_W-1:0] invuln_q, invuln_d;
    logic             pending_q, pending_d;
    logic             shot_req_q, shot_req_d;
    logic [7:0]       shot_x_q, shot_x_d;
    logic [17:0]      ledr_q, ledr_d;
    logic [7:0]       ledg_q, ledg_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic tick, go_rise, go_fall, blocked, hit_acc;

    assign tick    = bus.ship_update_en & ~ship_en_q;
    assign go_rise = bus.game_over_en & ~go_en_q;
    assign go_fall = ~bus.game_over_en & go_en_q;
    assign blocked = (health_q == 4'd0) | bus.game_over_en;
    assign hit_acc = bus.hit & bus.grid_update_en;

    always_comb begin
        x_d        = x_q;
        health_d   = health_q;
        cooldown_d = cooldown_q;
        invuln_d   = invuln_q;
        pending_d  = pending_q | hit_acc;
        shot_req_d = 1'b0;
        shot_x_d   = shot_x_q;

        if (go_fall) begin
            x_d        = X_START_V;
            health_d   = HEALTH_V;
            cooldown_d = '0;
            invuln_d   = '0;
            pending_d  = 1'b0;
        end else if (tick) begin
            if (!blocked) begin
                // shot column is taken from the position before this tick's move
                if (cooldown_q != '0) begin
                    cooldown_d = cooldown_q - 1'b1;
                end else if (bus.fire) begin
                    shot_req_d = 1'b1;
                    shot_x_d   = x_q + HALF_V;
                    cooldown_d = CD_V;
                end
                if (bus.move_left && !bus.move_right) begin
                    x_d = (x_q < X_LO) ? X_MIN_V : x_q - STEP_V;
                end else if (bus.move_right && !bus.move_left) begin
                    x_d = (x_q > X_HI) ? X_MAX_V : x_q + STEP_V;
                end
            end
            if ((pending_q | hit_acc) && invuln_q == '0 && health_q != 4'd0) begin
                health_d = health_q - 4'd1;
                invuln_d = INV_V;
            end else if (invuln_q != '0) begin
                invuln_d = invuln_q - 1'b1;
            end
            pending_d = 1'b0;
        end
    end

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        div_d  = div_q;
        if (!bus.game_over_en) begin
            ledr_d = '0;
            ledg_d = '0;
            div_d  = '0;
        end else if (go_rise) begin
            ledr_d = 18'h00001;
            ledg_d = 8'hAA;
            div_d  = '0;
        end else if (div_q == DIV_LAST) begin
            ledr_d = {ledr_q[16:0], ledr_q[17]};
            ledg_d = ~ledg_q;
            div_d  = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ship_en_q  <= 1'b0;
            go_en_q    <= 1'b0;
            x_q        <= X_START_V;
            health_q   <= HEALTH_V;
            cooldown_q <= '0;
            invuln_q   <= '0;
            pending_q  <= 1'b0;
            shot_req_q <= 1'b0;
            shot_x_q   <= '0;
            ledr_q     <= '0;
            ledg_q     <= '0;
            div_q      <= '0;
        end else begin
            ship_en_q  <= bus.ship_update_en;
            go_en_q    <= bus.game_over_en;
            x_q        <= x_d;
            health_q   <= health_d;
            cooldown_q <= cooldown_d;
            invuln_q   <= invuln_d;
            pending_q  <= pending_d;
            shot_req_q <= shot_req_d;
            shot_x_q   <= shot_x_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            div_q      <= div_d;
        end
    end

    assign bus.user_x      = x_q;
    assign bus.ship_health = health_q;
    assign bus.shot_req    = shot_req_q;
    assign bus.shot_x      = shot_x_q;
    assign bus.ledr        = ledr_q;
    assign bus.ledg        = ledg_q;
endmodule

// File: tb/tb_ship_datapath.sv
// tb/tb_ship_datapath.sv - directed and randomized checks of ship_datapath against a rule-level model
module tb_ship_datapath;
    logic clk = 1'b0;
    logic reset;
    ship_datapath_if bus();

    ship_datapath #(.LED_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_x, m_h, m_cd, m_inv, m_sx;
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic model_restart();
        m_x = 80; m_h = 8; m_cd = 0; m_inv = 0; m_pend = 0;
    endtask

    function automatic bit model_tick(input bit l, input bit r, input bit f, input bit hacc, input bit go);
        bit shot = 0;
        if (!(m_h == 0 || go)) begin
            if (m_cd != 0) m_cd--;
            else if (f) begin shot = 1; m_sx = m_x + 4; m_cd = 4; end
            if (l && !r)      m_x = (m_x - 2 < 0)   ? 0   : m_x - 2;
            else if (r && !l) m_x = (m_x + 2 > 152) ? 152 : m_x + 2;
        end
        if ((m_pend || hacc) && m_inv == 0 && m_h > 0) begin m_h--; m_inv = 8; end
        else if (m_inv > 0) m_inv--;
        m_pend = 0;
        return shot;
    endfunction

    task automatic tick(input bit l, input bit r, input bit f, input bit h, input bit g,
                        input int hold, output bit obs_shot);
        bit exp_shot;
        bus.move_left = l; bus.move_right = r; bus.fire = f;
        bus.hit = h; bus.grid_update_en = g; bus.ship_update_en = 1;
        exp_shot = model_tick(l, r, f, h & g, bus.game_over_en);
        cyc();
        obs_shot = bus.shot_req;
        chk("tick_shot_req", bus.shot_req, exp_shot);
        chk("tick_user_x", bus.user_x, m_x);
        chk("tick_health", bus.ship_health, m_h);
        if (exp_shot) chk("tick_shot_x", bus.shot_x, m_sx);
        bus.hit = 0;
        for (int i = 1; i <= hold; i++) begin
            if (i == hold) bus.ship_update_en = 0;
            cyc();
            if (i == 1) begin
                chk("shot_one_cycle", bus.shot_req, 0);
                chk("hold_user_x", bus.user_x, m_x);
            end
        end
        bus.grid_update_en = 0;
    endtask

    task automatic hit_only(input bit g);
        bus.hit = 1; bus.grid_update_en = g;
        cyc();
        bus.hit = 0; bus.grid_update_en = 0;
        if (g) m_pend = 1;
        cyc();
        chk("hit_only_health", bus.ship_health, m_h);
    endtask

    task automatic restart();
        bus.game_over_en = 1;
        cyc();
        bus.game_over_en = 0;
        cyc();
        model_restart();
        chk("restart_user_x", bus.user_x, m_x);
        chk("restart_health", bus.ship_health, m_h);
        chk("restart_ledr", bus.ledr, 0);
    endtask

    initial begin
        bit s;
        int changes, shots, k;
        reset = 1;
        bus.ship_update_en = 0; bus.grid_update_en = 0; bus.game_over_en = 0;
        bus.move_left = 0; bus.move_right = 0; bus.fire = 0; bus.hit = 0;
        cyc(); cyc();
        model_restart(); m_sx = 0;
        chk("rst_user_x", bus.user_x, 80);
        chk("rst_health", bus.ship_health, 8);
        chk("rst_shot_req", bus.shot_req, 0);
        chk("rst_shot_x", bus.shot_x, 0);
        chk("rst_ledr", bus.ledr, 0);
        chk("rst_ledg", bus.ledg, 0);
        reset = 0;
        cyc();

        // one tick per rising edge even with a long enable
        bus.move_right = 1; bus.ship_update_en = 1;
        s = model_tick(0, 1, 0, 0, 0);
        cyc();
        chk("hold_first_x", bus.user_x, 82);
        changes = 0;
        for (int i = 0; i < 999; i++) begin
            cyc();
            if (bus.user_x !== 8'd82) changes++;
        end
        chk("hold_no_more_moves", changes, 0);
        bus.ship_update_en = 0; bus.move_right = 0;
        cyc();

        for (int i = 0; i < 40; i++) tick(0, 1, 0, 0, 0, 1, s);
        chk("right_clamp", bus.user_x, 152);
        for (int i = 0; i < 80; i++) tick(1, 0, 0, 0, 0, 1, s);
        chk("left_clamp", bus.user_x, 0);

        restart();
        shots = 0;
        for (int t = 1; t <= 12; t++) begin
            tick(0, 0, 1, 0, 0, 1, s);
            chk("fire_schedule", s, (t == 1 || t == 6 || t == 11));
            if (s) begin shots++; chk("fire_shot_x", bus.shot_x, 84); end
        end
        chk("fire_count", shots, 3);

        restart();
        for (int t = 1; t <= 10; t++) begin
            tick(0, 0, 0, (t == 1 || t == 3 || t == 10), 1, 1, s);
            chk("invuln_health", bus.ship_health, (t < 10) ? 7 : 6);
        end
        for (int t = 0; t < 9; t++) tick(0, 0, 0, 0, 0, 1, s);
        hit_only(0);
        tick(0, 0, 0, 0, 0, 1, s);
        chk("ungated_hit_ignored", bus.ship_health, 6);

        restart();
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0, 1: tick($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                           ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(1, 3), s);
                2: hit_only($urandom_range(0, 1));
                default: begin cyc(); chk("idle_user_x", bus.user_x, m_x); end
            endcase
        end

        restart();
        for (int n = 0; n < 8; n++) begin
            hit_only(1);
            for (int t = 0; t < 9; t++) tick(0, 0, 0, 0, 0, 1, s);
        end
        chk("health_zero", bus.ship_health, 0);
        hit_only(1);
        tick(0, 1, 1, 1, 1, 1, s);
        chk("health_stays_zero", bus.ship_health, 0);
        chk("dead_no_shot", s, 0);

        bus.game_over_en = 1;
        for (int n = 0; n < 80; n++) begin
            cyc();
            k = n / 4;
            chk("led_ledr", bus.ledr, 32'd1 << (k % 18));
            chk("led_ledg", bus.ledg, (k % 2) ? 8'h55 : 8'hAA);
        end
        bus.game_over_en = 0;
        cyc();
        model_restart();
        chk("gameover_exit_x", bus.user_x, 80);
        chk("gameover_exit_health", bus.ship_health, 8);
        chk("gameover_exit_ledr", bus.ledr, 0);
        chk("gameover_exit_ledg", bus.ledg, 0);

        tick(0, 1, 1, 0, 0, 1, s);
        hit_only(1);
        tick(0, 0, 0, 0, 0, 1, s);
        chk("pre_reset_health", bus.ship_health, 7);
        bus.game_over_en = 1;
        cyc();
        tick(0, 1, 1, 0, 0, 1, s);
        chk("gameover_blocks_move", bus.user_x, 82);
        chk("gameover_blocks_fire", s, 0);
        reset = 1;
        cyc();
        model_restart(); m_sx = 0;
        chk("midgo_reset_x", bus.user_x, 80);
        chk("midgo_reset_health", bus.ship_health, 8);
        chk("midgo_reset_ledr", bus.ledr, 0);
        chk("midgo_reset_ledg", bus.ledg, 0);
        chk("midgo_reset_shot_x", bus.shot_x, 0);
        reset = 0;
        cyc();
        chk("post_reset_ledr", bus.ledr, 1);
        chk("post_reset_ledg", bus.ledg, 8'hAA);
        bus.game_over_en = 0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
